// File: rtl/sync_fifo_param.sv
// Single-clock FIFO of any depth, with occupancy count, almost thresholds, FWFT option and sticky error flags.
// Latency: FWFT=0 gives data one cycle after the read edge; FWFT=1 shows the head one cycle after it is written.
// Backpressure: writes to a full FIFO are dropped (overflow) unless a read is accepted in the same cycle; reads of an empty FIFO are dropped (underflow).
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;

    // All status flags come straight from the registered occupancy count.
    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    // A full FIFO can still take a write when a read frees a slot at the same edge.
    assign rd_acc = r_en & ~empty;
    assign wr_acc = w_en & (~full | rd_acc);

    // Storage is deliberately left unreset; only pointers define valid contents.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap by explicit compare so DEPTH need not be a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(wr_acc) - CW'(rd_acc);
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en & ~wr_acc) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (r_en & empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is visible whenever the FIFO holds data; zero when empty.
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_q;

            // Registered read port: updates only on an accepted read, holds otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else if (rd_acc) begin
                    data_q <= mem[rd_ptr];
                end
            end

            assign data_out = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-read and an FWFT instance share one stimulus stream.
// Latency: the standard instance is scored one cycle after each accepted read; the FWFT head is checked every cycle.
// Backpressure: overflow/underflow behaviour is predicted by a queue-based reference model.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          w_en    = 1'b0;
    logic          r_en    = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] d0_data_out, d1_data_out;
    logic          d0_full, d0_empty, d0_af, d0_ae, d0_ov, d0_un;
    logic          d1_full, d1_empty, d1_af, d1_ae, d1_ov, d1_un;
    logic [CW-1:0] d0_count, d1_count;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(d0_data_out), .full(d0_full), .empty(d0_empty),
        .almost_full(d0_af), .almost_empty(d0_ae), .count(d0_count),
        .clr_err(clr_err), .overflow(d0_ov), .underflow(d0_un)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(d1_data_out), .full(d1_full), .empty(d1_empty),
        .almost_full(d1_af), .almost_empty(d1_ae), .count(d1_count),
        .clr_err(clr_err), .overflow(d1_ov), .underflow(d1_un)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mq[$];      // reference contents, head at index 0
    logic [DW-1:0] exp_q[$];   // expected standard-mode read data
    bit            pend = 1'b0;
    bit            m_ov = 1'b0;
    bit            m_un = 1'b0;
    logic [DW-1:0] last0 = '0; // value the standard read port should be holding

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Compare every status output of both instances against the reference model.
    task automatic check_state();
        int            sz;
        logic [31:0]   exp_v;
        logic [DW-1:0] head;
        sz    = mq.size();
        exp_v = {23'd0, CW'(sz), sz == 0, sz == DEPTH, sz >= AF, sz <= AE, m_ov, m_un};
        check("status {count,empty,full,af,ae,ov,un} std",
              {23'd0, d0_count, d0_empty, d0_full, d0_af, d0_ae, d0_ov, d0_un}, exp_v);
        check("status {count,empty,full,af,ae,ov,un} fwft",
              {23'd0, d1_count, d1_empty, d1_full, d1_af, d1_ae, d1_ov, d1_un}, exp_v);
        head = (sz > 0) ? mq[0] : '0;
        check("fwft head data_out", {24'd0, d1_data_out}, {24'd0, head});
        check("std data_out hold", {24'd0, d0_data_out}, {24'd0, last0});
    endtask

    // One clock of stimulus: check the settled state, drive new inputs, advance the model.
    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        int sz;
        bit ra, wa;
        @(negedge clk);
        check_state();
        w_en = w; data_in = d; r_en = r; clr_err = c;
        sz = mq.size();
        ra = r && (sz > 0);
        wa = w && ((sz < DEPTH) || ra);
        pend = ra;
        if (ra) exp_q.push_back(mq.pop_front());
        if (wa) mq.push_back(d);
        if (c) begin m_ov = 1'b0; m_un = 1'b0; end
        if (w && !wa) m_ov = 1'b1;
        if (r && (sz == 0)) m_un = 1'b1;
    endtask

    // Monitor: after each edge that accepted a read, score the standard-mode output.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pend) begin
                pend = 1'b0;
                if (exp_q.size() == 0) begin
                    check("std read with empty scoreboard", 32'd1, 32'd0);
                end else begin
                    last0 = exp_q.pop_front();
                    check("std read data", {24'd0, d0_data_out}, {24'd0, last0});
                end
            end
        end
    end

    initial begin
        int wp, rp;
        bit w, r, c;

        // Power-on reset, checked while still asserted.
        #12;
        check_state();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full through every threshold.
        for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i * 8'h11), 1'b0, 1'b0);
        // Write into full: rejected, overflow, then cleared.
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        // Full with simultaneous read and write, then drain across the pointer wrap.
        cycle(1'b1, 8'h66, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        // Empty read with simultaneous write: read rejected, underflow set.
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        // Read timing of the two modes.
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a clock period with data stored.
        cycle(1'b1, 8'hB1, 1'b0, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0, 1'b0);
        cycle(1'b1, 8'hB3, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        mq.delete(); exp_q.delete(); pend = 1'b0;
        m_ov = 1'b0; m_un = 1'b0; last0 = '0;
        check_state();
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
        rst_n = 1'b1;
        cycle(1'b1, 8'hC7, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Randomized traffic with phases biased toward full, empty and balanced.
        wp = 50; rp = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) begin
                wp = $urandom_range(10, 90);
                rp = $urandom_range(10, 90);
            end
            w = ($urandom_range(0, 99) < wp);
            r = ($urandom_range(0, 99) < rp);
            c = ($urandom_range(0, 15) == 0);
            cycle(w, 8'($urandom), r, c);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
